// File: rtl/mux5_sel8_if.sv
// Bus bundle for the 8:1 register-address mux: select code, eight candidate
// fields and the combinational and registered results.
interface mux5_sel8_if #(
   parameter int WIDTH = 5
);
   logic [2:0]       choose;
   logic [WIDTH-1:0] input0;
   logic [WIDTH-1:0] input1;
   logic [WIDTH-1:0] input2;
   logic [WIDTH-1:0] input3;
   logic [WIDTH-1:0] input4;
   logic [WIDTH-1:0] input5;
   logic [WIDTH-1:0] input6;
   logic [WIDTH-1:0] input7;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;

   modport master (
      output choose, input0, input1, input2, input3,
             input4, input5, input6, input7,
      input  out, out_q
   );

   modport slave (
      input  choose, input0, input1, input2, input3,
             input4, input5, input6, input7,
      output out, out_q
   );
endinterface

// File: rtl/mux5_sel8.sv
// 8-to-1 mux for 5-bit destination-register fields with a combinational
// result and a one-cycle registered copy for pipelined consumers.
module mux5_sel8 #(
   parameter int WIDTH = 5
) (
   input  logic        clk,
   input  logic        reset,
   mux5_sel8_if.slave  bus
);

   logic [WIDTH-1:0] out_s;
   logic [WIDTH-1:0] out_q_r;

   // Select one candidate field; an unknown select resolves to zero.
   always_comb begin
      out_s = {WIDTH{1'b0}};
      case (bus.choose)
         3'd0:    out_s = bus.input0;
         3'd1:    out_s = bus.input1;
         3'd2:    out_s = bus.input2;
         3'd3:    out_s = bus.input3;
         3'd4:    out_s = bus.input4;
         3'd5:    out_s = bus.input5;
         3'd6:    out_s = bus.input6;
         3'd7:    out_s = bus.input7;
         default: out_s = {WIDTH{1'b0}};
      endcase
   end

   // Pipeline copy of the selection; reset clears it without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q_r <= {WIDTH{1'b0}};
      end else begin
         out_q_r <= out_s;
      end
   end

   assign bus.out   = out_s;
   assign bus.out_q = out_q_r;

endmodule

// File: tb/tb_mux5_sel8.sv
// Self-checking bench for mux5_sel8: directed sweeps, reset cases and random
// traffic compared against an array-indexed reference model.
`timescale 1ns/1ps
module tb_mux5_sel8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   logic [4:0] din [8];
   logic [4:0] exp_q;
   logic [4:0] pre_edge;
   logic [4:0] sweep_tbl [8];

   mux5_sel8_if #(.WIDTH(5)) bus ();

   mux5_sel8 #(.WIDTH(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] ref_out(input logic [2:0] sel);
      return din[sel];
   endfunction

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus.input0 = din[0];
      bus.input1 = din[1];
      bus.input2 = din[2];
      bus.input3 = din[3];
      bus.input4 = din[4];
      bus.input5 = din[5];
      bus.input6 = din[6];
      bus.input7 = din[7];
   endtask

   // Advance one clock; the register model captures the pre-edge selection.
   task automatic step(input string tag);
      pre_edge = (reset == 1'b0) ? 5'd0 : ref_out(bus.choose);
      @(posedge clk);
      #1;
      exp_q = pre_edge;
      chk(tag, bus.out_q, exp_q);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sweep_tbl[0] = 5'd5; sweep_tbl[1] = 5'd6; sweep_tbl[2] = 5'd7; sweep_tbl[3] = 5'd8;
      sweep_tbl[4] = 5'd1; sweep_tbl[5] = 5'd2; sweep_tbl[6] = 5'd3; sweep_tbl[7] = 5'd4;
      for (int k = 0; k < 8; k++) din[k] = sweep_tbl[k];
      reset = 1'b0;
      bus.choose = 3'd3;
      apply();
      #2;
      chk("reset_out_q", bus.out_q, 5'd0);
      chk("reset_out_comb", bus.out, 5'd8);
      step("reset_hold_q");

      reset = 1'b1;
      #1;
      chk("release_before_edge", bus.out_q, 5'd0);

      // Sweep twice so the select wraps 7 -> 0.
      bus.choose = 3'd0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("sweep_out", bus.out, sweep_tbl[i % 8]);
         chk("sweep_model", bus.out, ref_out(bus.choose));
         step("sweep_out_q");
         bus.choose = bus.choose + 3'd1;
      end
      chk("wrap_choose", {2'b00, bus.choose}, 5'd0);

      // Data-follow: only the selected input moves the output.
      bus.choose = 3'd3;
      din[3] = 5'd31;
      apply();
      #1;
      chk("follow_sel", bus.out, 5'd31);
      din[2] = 5'd0;
      apply();
      #1;
      chk("follow_unsel", bus.out, 5'd31);
      step("follow_q");

      // Async reset mid-cycle with out_q holding 4.
      for (int k = 0; k < 8; k++) din[k] = sweep_tbl[k];
      apply();
      bus.choose = 3'd7;
      step("pre_reset_q");
      step("load4_q");
      chk("load4_val", bus.out_q, 5'd4);
      #2;
      reset = 1'b0;
      #1;
      chk("async_clear_q", bus.out_q, 5'd0);
      chk("async_out_comb", bus.out, 5'd4);
      step("reset_held_q");
      #2;
      reset = 1'b1;
      #1;
      chk("rel_no_edge_q", bus.out_q, 5'd0);
      step("rel_first_cap");
      chk("rel_value", bus.out_q, 5'd4);

      // Extremes: all ones then all zeros across every select.
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 8; k++) din[k] = (pass == 0) ? 5'h1F : 5'h00;
         apply();
         for (int s = 0; s < 8; s++) begin
            bus.choose = 3'(s);
            #1;
            chk("ext_out", bus.out, (pass == 0) ? 5'h1F : 5'h00);
            step("ext_out_q");
         end
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 200; i++) begin
         for (int k = 0; k < 8; k++) din[k] = 5'($urandom);
         apply();
         bus.choose = 3'($urandom);
         #1;
         chk("rand_out", bus.out, ref_out(bus.choose));
         step("rand_out_q");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux5_sel8.md
Name: mux5_sel8

Overview:
- 8-to-1 multiplexer for 5-bit register-address fields, used in the MIPS datapath to select a destination register number.
- A 3-bit select, `choose`, picks one of eight 5-bit inputs.
- The selected value is driven combinationally on `out`.
- A registered copy is driven on `out_q` for pipelined consumers.

Parameters:
- WIDTH, 5, data width of each input and of both outputs.

Ports:
- clk  input  1  rising-edge clock; used only by the `out_q` register.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- choose  input  3  select code, 0..7.
- input0  input  WIDTH  data selected when choose=0.
- input1  input  WIDTH  data selected when choose=1.
- input2  input  WIDTH  data selected when choose=2.
- input3  input  WIDTH  data selected when choose=3.
- input4  input  WIDTH  data selected when choose=4.
- input5  input  WIDTH  data selected when choose=5.
- input6  input  WIDTH  data selected when choose=6.
- input7  input  WIDTH  data selected when choose=7.
- out  output  WIDTH  combinational selection result.
- out_q  output  WIDTH  registered selection result.

Behaviour:
- Combinational path:
  - out = input[choose] for every choose value 0..7.
  - Zero latency: out follows any change on choose or on the selected input within the same delta cycle.
  - Unselected inputs have no effect on out.
  - All 8 codes are legal; there is no invalid-select case in hardware.
  - When choose contains X/Z in simulation, out = 0 (default branch).
- Registered path:
  - On each rising clk edge with reset=1, out_q <= the current value of out.
  - out_q therefore lags out by exactly one clock cycle.
  - No enable; out_q updates every cycle.
- Reset:
  - reset=0 forces out_q = 0 immediately, asynchronously, with no clock edge required.
  - out_q stays 0 while reset is held low.
  - reset does not affect out, which stays purely combinational even during reset.
  - Deassertion (reset 0->1) is sampled synchronously. The first capture occurs at the first rising clk edge after deassertion.
  - Reset asserted mid-operation discards the held value of out_q; no partial state remains.
- Widths and wrap:
  - No arithmetic is performed; values pass bit-exact.
  - A driver that increments choose wraps 7->0; the mux then selects input0 again with no special handling.
- Simultaneous events:
  - If choose changes at the same clk edge as capture, out_q captures the pre-edge value of out (standard nonblocking register semantics).

Test Plan:
1. Sweep: input0..input7 = 5,6,7,8,1,2,3,4; step choose 0..7 every 10 ns -> out = 5,6,7,8,1,2,3,4 in order.
2. Wrap: continue incrementing choose past 7 -> choose=0 and out=5 again; the sequence repeats unchanged.
3. Data-follow: choose=3, change input3 from 8 to 31 -> out=31 immediately. Change input2 to 0 -> out stays 31.
4. Register latency: reset=1, choose stepping on clk edges -> out_q equals out from the previous cycle. Example: choose=1 at an edge gives out_q=6 after the next edge.
5. Async reset: with out_q=4, drive reset=0 between clk edges -> out_q=0 at once while out keeps its combinational value. Release reset -> out_q reloads at the next rising edge.
6. Extremes: all inputs = 5'h1F, then all = 5'h00, across all choose values -> out and out_q match bit-exactly.
